// File: rtl/reg_file_wr_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_wr_buffer_pkg
// Shared definitions for the register-file write buffer:
//   - default DEPTH / DATA_WIDTH / ADDR_WIDTH values
//   - wr_entry_t : one pending register write (destination + data), sized at
//                  the default widths
//   - youngest_match : returns the highest set position of an age-ordered
//                  match vector (position 0 = oldest entry, i.e. the head)
// The buffer supports DEPTH up to MAX_DEPTH.
// Optional feature macro used by the design: REG_FILE_WR_BUFFER_COALESCE_EN.
// ----------------------------------------------------------------------------
package reg_file_wr_buffer_pkg;

    localparam int DEPTH_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 5;

    localparam int MAX_DEPTH      = 64;
    localparam int MAX_IDX_W      = 6;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0] reg_addr;
        logic [DATA_WIDTH_DEF-1:0] data;
    } wr_entry_t;

    // Later (younger) positions overwrite earlier ones, so the result is the
    // youngest matching age. Returns 0 when nothing matches; callers qualify
    // the result with their own hit flag.
    function automatic logic [MAX_IDX_W-1:0] youngest_match(
        input logic [MAX_DEPTH-1:0] match_by_age
    );
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (match_by_age[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_file_wr_buffer_if.sv
// ----------------------------------------------------------------------------
// reg_file_wr_buffer_if
// Bundles every non-clock/reset signal of the write buffer.
//   producer side : in_valid, in_ready, in_reg, in_data
//   write port    : drain_stall, wr_en, wr_reg, wr_data
//   forwarding    : rd_reg_1/2 -> fwd_hit_1/2, fwd_data_1/2
//   status        : count (entries held)
// Handshake: a write transfers on a rising clock edge where in_valid and
// in_ready are both 1; the producer keeps in_valid, in_reg and in_data
// stable until that edge. in_ready never depends on in_valid.
// Modports: slave = the buffer, master = the environment driving it.
// ----------------------------------------------------------------------------
interface reg_file_wr_buffer_if
    import reg_file_wr_buffer_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_reg;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  drain_stall;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_reg_1;
    logic [ADDR_WIDTH-1:0] rd_reg_2;
    logic                  fwd_hit_1;
    logic [DATA_WIDTH-1:0] fwd_data_1;
    logic                  fwd_hit_2;
    logic [DATA_WIDTH-1:0] fwd_data_2;
    logic [CW-1:0]         count;

    modport slave (
        input  in_valid, in_reg, in_data, drain_stall, rd_reg_1, rd_reg_2,
        output in_ready, wr_en, wr_reg, wr_data,
               fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count
    );

    modport master (
        output in_valid, in_reg, in_data, drain_stall, rd_reg_1, rd_reg_2,
        input  in_ready, wr_en, wr_reg, wr_data,
               fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2, count
    );

endinterface

// File: rtl/reg_file_wr_fwd_match.sv
// ----------------------------------------------------------------------------
// reg_file_wr_fwd_match
// Searches the write buffer's entry array for one read address and returns
// the data of the youngest pending write to it.
//   rd_reg   : register being read (x0 never hits)
//   head     : slot of the oldest entry
//   count    : number of valid entries, starting at head
//   ent_reg  : destination register of every slot
//   ent_data : data of every slot
//   hit      : some valid entry targets rd_reg
//   data     : youngest matching data, 0 when no hit
// ----------------------------------------------------------------------------
module reg_file_wr_fwd_match
    import reg_file_wr_buffer_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0]             rd_reg,
    input  logic [$clog2(DEPTH)-1:0]          head,
    input  logic [$clog2(DEPTH):0]            count,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0]  ent_reg,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  ent_data,
    output logic                              hit,
    output logic [DATA_WIDTH-1:0]             data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [MAX_DEPTH-1:0] match_by_age;
    logic [PW-1:0]        slot;
    logic [PW-1:0]        age;
    logic [PW-1:0]        sel;

    // Walk the ring in age order (age 0 = head) so that the youngest match
    // is simply the highest set bit, independent of pointer wrap.
    always_comb begin
        match_by_age = '0;
        slot         = '0;
        for (int a = 0; a < DEPTH; a++) begin
            slot = head + PW'(a);
            if ((CW'(a) < count) && (ent_reg[slot] == rd_reg) && (rd_reg != '0)) begin
                match_by_age[a] = 1'b1;
            end
        end
    end

    assign age  = PW'(youngest_match(match_by_age));
    assign sel  = head + age;
    assign hit  = |match_by_age;
    assign data = hit ? ent_data[sel] : '0;

endmodule

// File: rtl/reg_file_wr_buffer.sv
// ----------------------------------------------------------------------------
// reg_file_wr_buffer
// Small FIFO of pending register writes feeding reg_file's single write port.
// Producers push (in_reg, in_data); one entry drains per cycle unless
// drain_stall holds the head. Reads can look up the newest pending value of
// a register through two forwarding ports.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; discards all pending writes
//   bus   : reg_file_wr_buffer_if.slave (push, drain, forwarding, count)
// Optional feature: define REG_FILE_WR_BUFFER_COALESCE_EN to let a push to
// the same register as the youngest entry overwrite that entry's data
// instead of allocating a new slot.
// ----------------------------------------------------------------------------
module reg_file_wr_buffer
    import reg_file_wr_buffer_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_file_wr_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]                     head;
    logic [PW-1:0]                     tail;
    logic [CW-1:0]                     count;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0]  ent_reg;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  ent_data;

    logic not_empty;
    logic pop;
    logic coalesce;
    logic accept;
    logic alloc;

    assign not_empty = (count != '0);
    assign pop       = not_empty & ~bus.drain_stall;

`ifdef REG_FILE_WR_BUFFER_COALESCE_EN
    logic [PW-1:0] tail_prev;
    assign tail_prev = tail - PW'(1);
    // A single entry that is draining this cycle is both head and youngest;
    // overwriting it would lose the new data, so it must allocate instead.
    assign coalesce = not_empty && (bus.in_reg != '0) &&
                      (ent_reg[tail_prev] == bus.in_reg) &&
                      !((count == CW'(1)) && pop);
`else
    assign coalesce = 1'b0;
`endif

    // rst_n gates in_ready so nothing is accepted while reset is asserted.
    // No pop credit: a full buffer refuses a push even while draining.
    assign bus.in_ready = rst_n & ((count < CW'(DEPTH)) | coalesce);

    assign accept = bus.in_valid & bus.in_ready;
    // Writes to x0 complete the handshake but are dropped.
    assign alloc  = accept & (bus.in_reg != '0) & ~coalesce;

    assign bus.wr_en   = pop;
    assign bus.wr_reg  = not_empty ? ent_reg[head]  : '0;
    assign bus.wr_data = not_empty ? ent_data[head] : '0;
    assign bus.count   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ent_reg  <= '0;
            ent_data <= '0;
        end else begin
            if (alloc) begin
                ent_reg[tail]  <= bus.in_reg;
                ent_data[tail] <= bus.in_data;
                tail           <= tail + PW'(1);
            end
`ifdef REG_FILE_WR_BUFFER_COALESCE_EN
            if (accept && coalesce) begin
                ent_data[tail_prev] <= bus.in_data;
            end
`endif
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + {{(CW-1){1'b0}}, alloc} - {{(CW-1){1'b0}}, pop};
        end
    end

    reg_file_wr_fwd_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd_1 (
        .rd_reg   (bus.rd_reg_1),
        .head     (head),
        .count    (count),
        .ent_reg  (ent_reg),
        .ent_data (ent_data),
        .hit      (bus.fwd_hit_1),
        .data     (bus.fwd_data_1)
    );

    reg_file_wr_fwd_match #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd_2 (
        .rd_reg   (bus.rd_reg_2),
        .head     (head),
        .count    (count),
        .ent_reg  (ent_reg),
        .ent_data (ent_data),
        .hit      (bus.fwd_hit_2),
        .data     (bus.fwd_data_2)
    );

endmodule

// File: tb/tb_reg_file_wr_buffer.sv
// ----------------------------------------------------------------------------
// tb_reg_file_wr_buffer
// Directed scenarios followed by a randomized phase. The reference is a
// queue of pending writes plus an array holding the expected register file
// contents; a small behavioural reg_file captures what the DUT drains.
// ----------------------------------------------------------------------------
module tb_reg_file_wr_buffer;
    import reg_file_wr_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_file_wr_buffer_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    reg_file_wr_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    wr_entry_t       q[$];
    logic [DW-1:0]   rf_model [32];
    logic [DW-1:0]   rf_dut   [32];
    logic [AW-1:0]   rd1 = '0;
    logic [AW-1:0]   rd2 = '0;

    // Behavioural reg_file: commits whatever the buffer drives on its port.
    always @(posedge clk) begin
        if (bus.wr_en) rf_dut[bus.wr_reg] <= bus.wr_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Newest pending value for a register; later queue entries are younger.
    task automatic model_fwd(input logic [AW-1:0] r, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (r != 0) begin
            foreach (q[i]) begin
                if (q[i].reg_addr == r) begin
                    hit = 1'b1;
                    d   = q[i].data;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs, compare every output against the
    // model, then advance the model across the edge.
    task automatic step(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                        input logic stall, output logic acc);
        logic          exp_wr_en, exp_ready, coal, h1, h2;
        logic [DW-1:0] d1, d2;
        wr_entry_t     e;
        @(negedge clk);
        bus.in_valid    = v;
        bus.in_reg      = r;
        bus.in_data     = d;
        bus.drain_stall = stall;
        bus.rd_reg_1    = rd1;
        bus.rd_reg_2    = rd2;
        #1;
        exp_wr_en = (q.size() != 0) && !stall;
        coal      = 1'b0;
`ifdef REG_FILE_WR_BUFFER_COALESCE_EN
        coal = (q.size() != 0) && (r != 0) && (q[q.size()-1].reg_addr == r) &&
               !((q.size() == 1) && exp_wr_en);
`endif
        exp_ready = (q.size() < DEPTH) || coal;
        model_fwd(rd1, h1, d1);
        model_fwd(rd2, h2, d2);
        check("count",      64'(bus.count),   64'(q.size()));
        check("in_ready",   64'(bus.in_ready), 64'(exp_ready));
        check("wr_en",      64'(bus.wr_en),    64'(exp_wr_en));
        check("wr_reg",     64'(bus.wr_reg),   64'(q.size() != 0 ? q[0].reg_addr : 5'd0));
        check("wr_data",    64'(bus.wr_data),  64'(q.size() != 0 ? q[0].data : 32'd0));
        check("fwd_hit_1",  64'(bus.fwd_hit_1),  64'(h1));
        check("fwd_data_1", 64'(bus.fwd_data_1), 64'(d1));
        check("fwd_hit_2",  64'(bus.fwd_hit_2),  64'(h2));
        check("fwd_data_2", 64'(bus.fwd_data_2), 64'(d2));
        acc = v && exp_ready;
        @(posedge clk);
        if (acc && r != 0) begin
            if (coal) q[q.size()-1].data = d;
            else      q.push_back('{reg_addr: r, data: d});
        end
        if (exp_wr_en) begin
            e = q.pop_front();
            rf_model[e.reg_addr] = e.data;
        end
    endtask

    task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d, input logic stall);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, r, d, stall, acc);
            n++;
        end
        check("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        logic acc;
        int   n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            step(1'b0, '0, '0, 1'b0, acc);
            n++;
        end
        @(negedge clk);
        check("drain_count", 64'(bus.count), 64'd0);
    endtask

    initial begin
        logic          acc, pend, stall;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        for (int i = 0; i < 32; i++) begin
            rf_model[i] = '0;
            rf_dut[i]   = '0;
        end
        bus.in_valid    = 1'b0;
        bus.in_reg      = '0;
        bus.in_data     = '0;
        bus.drain_stall = 1'b0;
        bus.rd_reg_1    = 5'd5;
        bus.rd_reg_2    = '0;

        // Held in reset
        #1;
        check("rst_count",    64'(bus.count),     64'd0);
        check("rst_in_ready", 64'(bus.in_ready),  64'd0);
        check("rst_wr_en",    64'(bus.wr_en),     64'd0);
        check("rst_fwd_hit",  64'(bus.fwd_hit_1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        rd1 = 5'd5;
        step(1'b0, '0, '0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, acc);

        // Single write
        rd1 = 5'd3;
        push(5'd3, 32'hDEADBEEF, 1'b0);
        step(1'b0, '0, '0, 1'b0, acc);
        drain();
        check("x3_commit", 64'(rf_dut[3]), 64'h0000_0000_DEAD_BEEF);

        // Fill under stall, fifth write held until the stall lifts
        rd1 = 5'd2;
        rd2 = 5'd4;
        for (int i = 1; i <= 4; i++) push(AW'(i), DW'(32'h11 * i), 1'b1);
        step(1'b1, 5'd5, 32'h55, 1'b1, acc);
        check("x5_held_a", 64'(acc), 64'd0);
        step(1'b1, 5'd5, 32'h55, 1'b1, acc);
        check("x5_held_b", 64'(acc), 64'd0);
        push(5'd5, 32'h55, 1'b0);
        drain();
        for (int i = 1; i <= 5; i++) check("fill_commit", 64'(rf_dut[i]), 64'(32'h11 * i));

        // Youngest-match forwarding
        rd1 = 5'd7;
        push(5'd7, 32'hA, 1'b1);
        push(5'd7, 32'hB, 1'b1);
        step(1'b0, '0, '0, 1'b1, acc);
        drain();
        check("x7_commit", 64'(rf_dut[7]), 64'hB);

        // x0 writes allocate nothing; long back-to-back run wraps pointers
        rd1 = 5'd0;
        push(5'd0, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            rd2 = AW'(10 + i);
            push(AW'(10 + i), $urandom, 1'b0);
        end
        drain();

        // Asynchronous reset with three writes pending
        rd1 = 5'd21;
        for (int i = 0; i < 3; i++) push(AW'(20 + i), 32'hC0DE_0000 + i, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_count",   64'(bus.count),     64'd0);
        check("mid_rst_wr_en",   64'(bus.wr_en),     64'd0);
        check("mid_rst_ready",   64'(bus.in_ready),  64'd0);
        check("mid_rst_fwd_hit", 64'(bus.fwd_hit_1), 64'd0);
        #1 rst_n = 1'b1;
        q.delete();
        step(1'b0, '0, '0, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, acc);
        for (int i = 0; i < 3; i++) check("rst_lost", 64'(rf_dut[20 + i]), 64'd0);

        // Randomized traffic; a pending write stays stable until accepted
        pend = 1'b0;
        r    = '0;
        d    = '0;
        for (int n = 0; n < 300; n++) begin
            if (!pend) begin
                pend = ($urandom_range(0, 3) != 0);
                r    = AW'($urandom_range(0, 7));
                d    = $urandom;
            end
            stall = ($urandom_range(0, 3) == 0);
            rd1   = AW'($urandom_range(0, 7));
            rd2   = AW'($urandom_range(0, 7));
            step(pend, r, d, stall, acc);
            if (acc) pend = 1'b0;
        end
        drain();
        for (int i = 0; i < 32; i++) check("final_rf", 64'(rf_dut[i]), 64'(rf_model[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
